// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between instruction fetch
// (port 0, read-only) and the load/store unit (port 1, read/write).
// Port 1 wins conflicts until port 0 has lost MAXRUN conflicts in a row,
// then port 0 is forced through once. MAXRUN=0 gives pure fixed priority.
// The RAM registers its read address, so read data shows up one cycle after
// the accepting edge and is qualified by a per-port valid strobe.
// Optional grant/stall statistics are compiled in with `define RAM_ARB_STATS_EN.
// ADDRWIDTH must match the ADDRWIDTH of the attached RAM instance.

module ram_port_arbiter #(
   parameter int ADDRWIDTH = 6,
   parameter int DATAWIDTH = 32,
   parameter int MAXRUN    = 4,
   parameter int STATWIDTH = 16
) (
   input  logic                 iClk,
   input  logic                 iRst_n,
   input  logic                 iReq0,
   input  logic [ADDRWIDTH-1:0] iAddr0,
   output logic                 oGnt0,
   output logic [DATAWIDTH-1:0] oRdata0,
   output logic                 oRvalid0,
   input  logic                 iReq1,
   input  logic                 iWe1,
   input  logic [ADDRWIDTH-1:0] iAddr1,
   input  logic [DATAWIDTH-1:0] iWdata1,
   output logic                 oGnt1,
   output logic [DATAWIDTH-1:0] oRdata1,
   output logic                 oRvalid1,
   output logic                 oRamWR,
   output logic [ADDRWIDTH-1:0] oRamAddress,
   output logic [DATAWIDTH-1:0] oRamWriteData,
   input  logic [DATAWIDTH-1:0] iRamReadData
`ifdef RAM_ARB_STATS_EN
   ,
   input  logic                 iStatClr,
   output logic [STATWIDTH-1:0] oGntCnt0,
   output logic [STATWIDTH-1:0] oGntCnt1,
   output logic [STATWIDTH-1:0] oStallCnt0
`endif
);

   // The run counter needs at least one bit even when the guard is disabled.
   localparam int RUNW = (MAXRUN < 1) ? 1 : $clog2(MAXRUN + 1);
   localparam logic [RUNW-1:0] RUNMAX = RUNW'(MAXRUN);

   logic [RUNW-1:0] runCnt_q, runCnt_d;
   logic            forceP0;
   logic            gnt0, gnt1;
   logic            rvalid0_q, rvalid0_d;
   logic            rvalid1_q, rvalid1_d;

   // Port 1 wins conflicts unless port 0 has already lost MAXRUN in a row.
   always_comb begin
      forceP0 = (MAXRUN != 0) && (runCnt_q == RUNMAX);
      gnt1    = iReq1 && !(iReq0 && forceP0);
      gnt0    = iReq0 && !gnt1;
   end

   // Count consecutive conflicts lost by port 0; any port 0 grant or idle port 0 resets the run.
   always_comb begin
      runCnt_d = runCnt_q;
      if (!iReq0 || gnt0) begin
         runCnt_d = '0;
      end else if (runCnt_q != RUNMAX) begin
         runCnt_d = runCnt_q + 1'b1;
      end
   end

   // A read accepted now has its data on the RAM output next cycle; writes raise no strobe.
   always_comb begin
      rvalid0_d = gnt0;
      rvalid1_d = gnt1 && !iWe1;
   end

   // Run counter and read-valid registers; reset drops any read in flight.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         runCnt_q  <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
      end else begin
         runCnt_q  <= runCnt_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
      end
   end

   assign oGnt0         = gnt0;
   assign oGnt1         = gnt1;
   assign oRamAddress   = gnt1 ? iAddr1 : iAddr0;
   assign oRamWR        = gnt1 && iWe1;
   assign oRamWriteData = iWdata1;
   assign oRdata0       = iRamReadData;
   assign oRdata1       = iRamReadData;
   assign oRvalid0      = rvalid0_q;
   assign oRvalid1      = rvalid1_q;

`ifdef RAM_ARB_STATS_EN
   logic [STATWIDTH-1:0] gntCnt0_q, gntCnt0_d;
   logic [STATWIDTH-1:0] gntCnt1_q, gntCnt1_d;
   logic [STATWIDTH-1:0] stallCnt0_q, stallCnt0_d;

   // Saturating statistics counters with a synchronous clear.
   always_comb begin
      gntCnt0_d   = gntCnt0_q;
      gntCnt1_d   = gntCnt1_q;
      stallCnt0_d = stallCnt0_q;
      if (iStatClr) begin
         gntCnt0_d   = '0;
         gntCnt1_d   = '0;
         stallCnt0_d = '0;
      end else begin
         if (gnt0 && !(&gntCnt0_q)) begin
            gntCnt0_d = gntCnt0_q + 1'b1;
         end
         if (gnt1 && !(&gntCnt1_q)) begin
            gntCnt1_d = gntCnt1_q + 1'b1;
         end
         if (iReq0 && !gnt0 && !(&stallCnt0_q)) begin
            stallCnt0_d = stallCnt0_q + 1'b1;
         end
      end
   end

   // Statistics registers.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         gntCnt0_q   <= '0;
         gntCnt1_q   <= '0;
         stallCnt0_q <= '0;
      end else begin
         gntCnt0_q   <= gntCnt0_d;
         gntCnt1_q   <= gntCnt1_d;
         stallCnt0_q <= stallCnt0_d;
      end
   end

   assign oGntCnt0   = gntCnt0_q;
   assign oGntCnt1   = gntCnt1_q;
   assign oStallCnt0 = stallCnt0_q;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: table-driven bench for ram_port_arbiter with a
// behavioural single-port RAM and a read-data scoreboard per port.
// A second instance with MAXRUN=0 shares the request inputs to check the
// pure fixed-priority configuration.

module tb_ram_port_arbiter;

   localparam int AW = 6;
   localparam int DW = 32;

   typedef struct {
      logic          r0;
      logic [AW-1:0] a0;
      logic          r1;
      logic          we1;
      logic [AW-1:0] a1;
      logic [DW-1:0] d1;
      logic          g0;
      logic          g1;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req0, req1, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata1;
   logic          gnt0, gnt1, rvalid0, rvalid1;
   logic [DW-1:0] rdata0, rdata1;
   logic          ramWr;
   logic [AW-1:0] ramAddr;
   logic [DW-1:0] ramWData, ramRData;

   logic          altGnt0, altGnt1, altRvalid0, altRvalid1, altRamWr;
   logic [DW-1:0] altRdata0, altRdata1, altRamWData;
   logic [AW-1:0] altRamAddr;
   logic [DW-1:0] altRamRData = '0;

`ifdef RAM_ARB_STATS_EN
   logic          statClr;
   logic [15:0]   gntCnt0, gntCnt1, stallCnt0;
   logic [15:0]   altGntCnt0, altGntCnt1, altStallCnt0;
`endif

   logic [DW-1:0] ramMem [0:63];
   logic [DW-1:0] refMem [0:63];
   logic [AW-1:0] ramAddrQ;
   logic [DW-1:0] q0 [$];
   logic [DW-1:0] q1 [$];
   logic          expV0 = 1'b0;
   logic          expV1 = 1'b0;
   int            checks = 0;
   int            errors = 0;
   vec_t          vecs [11];

   // Free-running clock.
   always #5 clk = ~clk;

   ram_port_arbiter #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .MAXRUN(4), .STATWIDTH(16)) dut (
      .iClk(clk), .iRst_n(rst_n),
      .iReq0(req0), .iAddr0(addr0), .oGnt0(gnt0), .oRdata0(rdata0), .oRvalid0(rvalid0),
      .iReq1(req1), .iWe1(we1), .iAddr1(addr1), .iWdata1(wdata1),
      .oGnt1(gnt1), .oRdata1(rdata1), .oRvalid1(rvalid1),
      .oRamWR(ramWr), .oRamAddress(ramAddr), .oRamWriteData(ramWData), .iRamReadData(ramRData)
`ifdef RAM_ARB_STATS_EN
      , .iStatClr(statClr), .oGntCnt0(gntCnt0), .oGntCnt1(gntCnt1), .oStallCnt0(stallCnt0)
`endif
   );

   ram_port_arbiter #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .MAXRUN(0), .STATWIDTH(16)) dutFixed (
      .iClk(clk), .iRst_n(rst_n),
      .iReq0(req0), .iAddr0(addr0), .oGnt0(altGnt0), .oRdata0(altRdata0), .oRvalid0(altRvalid0),
      .iReq1(req1), .iWe1(we1), .iAddr1(addr1), .iWdata1(wdata1),
      .oGnt1(altGnt1), .oRdata1(altRdata1), .oRvalid1(altRvalid1),
      .oRamWR(altRamWr), .oRamAddress(altRamAddr), .oRamWriteData(altRamWData), .iRamReadData(altRamRData)
`ifdef RAM_ARB_STATS_EN
      , .iStatClr(statClr), .oGntCnt0(altGntCnt0), .oGntCnt1(altGntCnt1), .oStallCnt0(altStallCnt0)
`endif
   );

   // Behavioural single-port RAM: synchronous write, registered read address.
   always @(posedge clk) begin
      if (ramWr) ramMem[ramAddr] <= ramWData;
      ramAddrQ <= ramAddr;
   end
   assign ramRData = ramMem[ramAddrQ];

   // Hard stop in case something goes badly wrong.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic checkValids();
      logic [DW-1:0] e;
      checkOutput("rvalid0", 32'(rvalid0), 32'(expV0));
      checkOutput("rvalid1", 32'(rvalid1), 32'(expV1));
      if (expV0 && q0.size() > 0) begin
         e = q0.pop_front();
         checkOutput("rdata0", rdata0, e);
      end
      if (expV1 && q1.size() > 0) begin
         e = q1.pop_front();
         checkOutput("rdata1", rdata1, e);
      end
   endtask

   // Drive one cycle from a vector, check the combinational side, then the returned read.
   task automatic applyStimulus(input vec_t v);
      req0 = v.r0; addr0 = v.a0; req1 = v.r1; we1 = v.we1; addr1 = v.a1; wdata1 = v.d1;
      #1;
      checkOutput("gnt0", 32'(gnt0), 32'(v.g0));
      checkOutput("gnt1", 32'(gnt1), 32'(v.g1));
      checkOutput("ramWr", 32'(ramWr), 32'(v.g1 & v.we1));
      checkOutput("ramAddr", 32'(ramAddr), 32'(v.g1 ? v.a1 : v.a0));
      checkOutput("ramWData", ramWData, v.d1);
      if (v.g0) q0.push_back(refMem[v.a0]);
      if (v.g1 && !v.we1) q1.push_back(refMem[v.a1]);
      if (v.g1 && v.we1) refMem[v.a1] = v.d1;
      @(posedge clk);
      expV0 = v.g0;
      expV1 = v.g1 & ~v.we1;
      @(negedge clk);
      checkValids();
   endtask

   function automatic vec_t conflictVec(input int i, input logic g0);
      vec_t v;
      v = '{r0: 1'b1, a0: 6'd20, r1: 1'b1, we1: 1'b0, a1: 6'(i % 10), d1: 32'h0, g0: g0, g1: !g0};
      return v;
   endfunction

   initial begin
      vec_t v;
      vecs[0]  = '{1'b1, 6'd5,  1'b0, 1'b0, 6'd0,  32'h0,        1'b1, 1'b0};
      vecs[1]  = '{1'b0, 6'd0,  1'b1, 1'b1, 6'd9,  32'h12345678, 1'b0, 1'b1};
      vecs[2]  = '{1'b1, 6'd9,  1'b0, 1'b0, 6'd0,  32'h0,        1'b1, 1'b0};
      vecs[3]  = '{1'b0, 6'd0,  1'b1, 1'b0, 6'd5,  32'h0,        1'b0, 1'b1};
      vecs[4]  = '{1'b1, 6'd3,  1'b1, 1'b0, 6'd7,  32'h0,        1'b0, 1'b1};
      vecs[5]  = '{1'b0, 6'd17, 1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 1'b0};
      vecs[6]  = '{1'b1, 6'd2,  1'b1, 1'b1, 6'd2,  32'hA5A5A5A5, 1'b0, 1'b1};
      vecs[7]  = '{1'b1, 6'd2,  1'b0, 1'b0, 6'd0,  32'h0,        1'b1, 1'b0};
      vecs[8]  = '{1'b1, 6'd4,  1'b1, 1'b0, 6'd2,  32'h0,        1'b0, 1'b1};
      vecs[9]  = '{1'b1, 6'd4,  1'b1, 1'b1, 6'd10, 32'h0BADF00D, 1'b0, 1'b1};
      vecs[10] = '{1'b1, 6'd4,  1'b0, 1'b0, 6'd0,  32'h0,        1'b1, 1'b0};

      for (int i = 0; i < 64; i++) begin
         ramMem[i] = 32'hC0DE0000 + 32'(i);
         refMem[i] = 32'hC0DE0000 + 32'(i);
      end
      ramMem[5] = 32'hDEADBEEF;
      refMem[5] = 32'hDEADBEEF;

      req0 = 1'b0; req1 = 1'b0; we1 = 1'b0; addr0 = '0; addr1 = '0; wdata1 = '0;
`ifdef RAM_ARB_STATS_EN
      statClr = 1'b0;
`endif
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("resetRvalid0", 32'(rvalid0), 32'd0);
      checkOutput("resetRvalid1", 32'(rvalid1), 32'd0);
      checkOutput("idleGnt0", 32'(gnt0), 32'd0);
      checkOutput("idleGnt1", 32'(gnt1), 32'd0);
      rst_n = 1'b1;
      $display("[TB] reset released, running vector table");

      for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);

      $display("[TB] continuous conflict, starvation guard");
      for (int i = 0; i < 20; i++) begin
         applyStimulus(conflictVec(i, (i % 5) == 4));
         checkOutput("fixedGnt0", 32'(altGnt0), 32'd0);
         checkOutput("fixedGnt1", 32'(altGnt1), 32'd1);
      end
      v = '{r0: 1'b1, a0: 6'd20, r1: 1'b0, we1: 1'b0, a1: 6'd0, d1: 32'h0, g0: 1'b1, g1: 1'b0};
      applyStimulus(v);
      checkOutput("fixedGnt0Drop", 32'(altGnt0), 32'd1);
      checkOutput("fixedGnt1Drop", 32'(altGnt1), 32'd0);

      $display("[TB] reset with a read in flight");
      for (int i = 0; i < 3; i++) applyStimulus(conflictVec(i, 1'b0));
      req0 = 1'b1; req1 = 1'b1; we1 = 1'b0; addr1 = 6'd7;
      #1;
      checkOutput("preResetGnt1", 32'(gnt1), 32'd1);
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      @(posedge clk); @(negedge clk);
      checkOutput("inResetRvalid1", 32'(rvalid1), 32'd0);
      checkOutput("inResetRvalid0", 32'(rvalid0), 32'd0);
      @(posedge clk); @(negedge clk);
      checkOutput("inResetRvalid1b", 32'(rvalid1), 32'd0);
      rst_n = 1'b1;
      expV0 = 1'b0; expV1 = 1'b0;
      #1;
      checkOutput("postResetRvalid1", 32'(rvalid1), 32'd0);
      @(negedge clk);
      checkOutput("postResetRvalid1b", 32'(rvalid1), 32'd0);
      for (int i = 0; i < 5; i++) applyStimulus(conflictVec(i, i == 4));

`ifdef RAM_ARB_STATS_EN
      $display("[TB] statistics counters");
      v = '{r0: 1'b0, a0: 6'd0, r1: 1'b0, we1: 1'b0, a1: 6'd0, d1: 32'h0, g0: 1'b0, g1: 1'b0};
      statClr = 1'b1;
      applyStimulus(v);
      statClr = 1'b0;
      checkOutput("clrGntCnt0", 32'(gntCnt0), 32'd0);
      checkOutput("clrGntCnt1", 32'(gntCnt1), 32'd0);
      checkOutput("clrStallCnt0", 32'(stallCnt0), 32'd0);
      for (int i = 0; i < 10; i++) applyStimulus(conflictVec(i, (i % 5) == 4));
      checkOutput("statGntCnt0", 32'(gntCnt0), 32'd2);
      checkOutput("statGntCnt1", 32'(gntCnt1), 32'd8);
      checkOutput("statStallCnt0", 32'(stallCnt0), 32'd8);
      statClr = 1'b1;
      applyStimulus(v);
      statClr = 1'b0;
      checkOutput("clr2GntCnt0", 32'(gntCnt0), 32'd0);
      checkOutput("clr2GntCnt1", 32'(gntCnt1), 32'd0);
      checkOutput("clr2StallCnt0", 32'(stallCnt0), 32'd0);
`endif

      checkOutput("scoreboardEmpty", 32'(q0.size() + q1.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single-port RAM (registered read address, 1-cycle read latency, synchronous write) between two requesters:
  - port 0: instruction fetch, read-only;
  - port 1: load/store unit, read/write.
- Port 1 has priority, with a starvation guard that forces a port-0 grant after a bounded run of lost conflicts.
- Tracks the in-flight read and returns data with a per-port valid strobe.
- Sits between the core's fetch/LSU stages and the RAM instance.

Parameters:
- ADDRWIDTH, 6, word-address width; must equal the RAM's ADDRWIDTH.
- DATAWIDTH, 32, data width.
- MAXRUN, 4, max consecutive conflict cycles port 1 may win before port 0 is forced; 0 disables the guard (pure fixed priority).
- STATWIDTH, 16, statistics counter width (used only with RAM_ARB_STATS_EN).

Ports:
- iClk  in  1  clock, rising edge
- iRst_n  in  1  asynchronous active-low reset
- iReq0  in  1  port 0 read request, held until granted
- iAddr0  in  ADDRWIDTH  port 0 address
- oGnt0  out  1  port 0 accepted this cycle (combinational)
- oRdata0  out  DATAWIDTH  port 0 read data
- oRvalid0  out  1  oRdata0 valid (registered)
- iReq1  in  1  port 1 request, held until granted
- iWe1  in  1  port 1 write (1) / read (0)
- iAddr1  in  ADDRWIDTH  port 1 address
- iWdata1  in  DATAWIDTH  port 1 write data
- oGnt1  out  1  port 1 accepted this cycle (combinational)
- oRdata1  out  DATAWIDTH  port 1 read data
- oRvalid1  out  1  oRdata1 valid (registered)
- oRamWR  out  1  to RAM iWR
- oRamAddress  out  ADDRWIDTH  to RAM iAddress
- oRamWriteData  out  DATAWIDTH  to RAM iWriteData
- iRamReadData  in  DATAWIDTH  from RAM oReadData

Behaviour:
- Reset, asynchronous on iRst_n low:
  - runCnt=0, oRvalid0=0, oRvalid1=0, stats=0.
  - Grants stay purely combinational from requests and state.
  - An in-flight read is dropped: no valid is issued after reset releases.
- Arbitration, combinational, same cycle; a transaction is accepted at the rising edge where its grant is high:
  - Only one requester: it is granted.
  - Both requesting: port 1 wins unless MAXRUN!=0 and runCnt==MAXRUN, in which case port 0 wins.
  - oGnt0 and oGnt1 are never both 1.
- runCnt, width $clog2(MAXRUN+1), minimum 1:
  - Increments, saturating at MAXRUN, on each cycle where both request and port 1 wins.
  - Clears to 0 on a port 0 grant, or on a cycle where iReq0=0.
- RAM drive:
  - oRamAddress = iAddr1 when oGnt1, otherwise iAddr0 (a harmless read when idle).
  - oRamWR = oGnt1 & iWe1.
  - oRamWriteData = iWdata1 always.
- Read return:
  - oRvalid0 <= oGnt0; oRvalid1 <= oGnt1 & ~iWe1.
  - oRdata0 = oRdata1 = iRamReadData; the valids qualify it.
  - Latency: accepted at edge N, data valid during cycle N+1, i.e. 1 cycle.
  - Back-to-back grants on consecutive cycles are legal; throughput is 1 access per cycle.
- Writes: no valid strobe; a write is complete at its acceptance edge.
- Read-after-write to the same address on the next cycle (either port) returns the new data; no bypass is needed because the RAM registers the address.
- Simultaneous write and read: impossible; one grant per cycle.
- Requester deasserting before grant: allowed; no state is left behind.

Optional Feature:
- Macro RAM_ARB_STATS_EN.
- Defined:
  - Adds input iStatClr, a synchronous clear.
  - Adds STATWIDTH-wide outputs:
    - oGntCnt0: port 0 grants.
    - oGntCnt1: port 1 grants.
    - oStallCnt0: cycles with iReq0 & ~oGnt0.
  - All counters are registered, saturate at all-ones, and reset to 0 (async reset or iStatClr).
- Undefined: none of these ports or counters exist; arbitration is identical.

Test Plan:
- Port 0 only, iAddr0=5 with RAM[5]=0xDEADBEEF preloaded:
  - oGnt0=1 in the same cycle.
  - Next cycle oRvalid0=1, oRdata0=0xDEADBEEF; oRvalid1=0.
- Port 1 writes 0x12345678 to addr 9, then port 0 reads addr 9 the next cycle:
  - Write accepted with oRamWR=1 for 1 cycle and no valid strobe.
  - Read returns 0x12345678 with oRvalid0=1.
- Both requesting continuously, MAXRUN=4, port 1 reads addrs 0..9:
  - Grant pattern is port 1 ×4, port 0 ×1, repeating.
  - Never both grants high; runCnt returns to 0 after each port 0 grant.
- MAXRUN=0, both requesting for 20 cycles -> oGnt0 stays 0 throughout; port 0 is granted in the cycle iReq1 drops.
- iRst_n asserted one cycle after a port 1 read grant -> oRvalid1 stays 0 during and after reset; runCnt=0; first post-reset request is granted normally.
- RAM_ARB_STATS_EN defined, 10 conflict cycles with MAXRUN=4:
  - oGntCnt1=8, oGntCnt0=2, oStallCnt0=8.
  - iStatClr pulse zeroes all three next cycle.
